cp0_ctrl: RTL and testbench
===========================

CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 Param N_HW_INT, default 6, number of hardware interrupt lines wired into Cause.IP; legal 1..6.
REQ-002 Param COUNT_DIV, default 1, clock cycles per Count increment; legal 1..16.
REQ-003 Param PRID_VAL, default 32'h004C_0102, PRId read value.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wb_we_i  in  1  WB-stage CP0 write enable.
- wb_waddr_i  in  5  WB-stage CP0 write address.
- wb_wdata_i  in  32  WB-stage CP0 write data.
- mem_we_i  in  1  MEM-stage forward enable.
- mem_waddr_i  in  5  MEM-stage forward address.
- mem_wdata_i  in  32  MEM-stage forward data.
- raddr_i  in  5  read address.
- int_i  in  N_HW_INT  hardware interrupt lines.
- exc_valid_i  in  1  commit exception this cycle.
- exc_code_i  in  5  ExcCode value.
- exc_pc_i  in  32  faulting instruction address.
- exc_bd_i  in  1  faulting instruction is in a delay slot.
- exc_badvaddr_i  in  32  faulting data/fetch address.
- eret_i  in  1  ERET commits this cycle.
- rdata_o  out  32  read data.
- status_o / cause_o / epc_o  out  32 each  forwarded register views.
- timer_int_o  out  1  timer interrupt pending.
- int_req_o  out  1  interrupt request to the exception unit.

Function
REQ-006 Register map: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16. Unmapped reads return 0. Unmapped writes are ignored.
REQ-007 Count increments by 1 on every COUNT_DIV-th cycle via an internal divider, wrapping 32'hFFFF_FFFF->0. A Count write wins over the increment and resets the divider.
REQ-008 When Count==Compare (any value, including 0), timer_int_o sets on the next edge. It stays set (sticky) until a Compare write. A Compare write and a match in the same cycle leave it clear.
REQ-009 Cause.IP[2+k] = int_i[k] for k<N_HW_INT, registered each cycle. Unused IP bits read 0. IP[7] = int_i[5] | timer_int_o.
REQ-010 Writable Cause bits: IP[1:0], IV(23), WP(22). All other Cause bits are hardware-owned.
REQ-011 On exc_valid_i:
- If Status.EXL=0: EPC <= exc_pc_i - (exc_bd_i ? 4 : 0), and Cause.BD <= exc_bd_i.
- If Status.EXL=1: EPC and BD are kept.
- Always: Cause.ExcCode <= exc_code_i, and Status.EXL <= 1.
- For ExcCode 4 or 5 only: BadVAddr <= exc_badvaddr_i.
REQ-012 On eret_i without exc_valid_i: Status.EXL <= 0.
REQ-013 Same-cycle priority per field: exception > eret > wb write > hardware update.
REQ-014 int_req_o = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), combinational from forwarded status/cause.
REQ-015 rdata_o, status_o, cause_o, epc_o are combinational.
- Source priority: MEM forward on address hit, then WB forward on address hit, then registers.
- status_o, cause_o and epc_o are each forwarded independently of raddr_i.
REQ-016 Config (32'h0000_8000) and PRId are read-only.

Reset
REQ-017 While rst=1 at an edge:
- Count, Compare, Cause, EPC, BadVAddr and the divider reset to 0.
- Status resets to 32'h1000_0000.
- timer_int_o resets to 0.
REQ-018 While rst=1, rdata_o, int_req_o and timer_int_o are 0. Reset asserted mid-exception discards that exception.

Configuration
REQ-019 Macro CP0_TIMER_EN.
- Defined: Count, Compare and the timer behave per REQ-007/008.
- Undefined: Count and Compare read 0, their writes are ignored, timer_int_o is tied 0, and no divider logic is present.

Verification
REQ-020 COUNT_DIV=2, reset release -> Count reads 5 after 10 cycles. Write Count=7 -> next read 7.
REQ-021 Compare=3, free-run -> timer_int_o=1 one cycle after Count==3 and stays 1. Write Compare=0 -> timer_int_o=0 next cycle.
REQ-022 exc_valid_i, ExcCode=8, exc_pc_i=0x100, exc_bd_i=1, EXL=0 -> EPC=0xFC, Cause.BD=1, EXL=1. Second exception at 0x200 -> EPC stays 0xFC.
REQ-023 ExcCode=4, exc_badvaddr_i=0x1003 -> BadVAddr=0x1003. Simultaneous eret_i -> EXL stays 1.
REQ-024 Status=0x0000_0401, int_i[0]=1, N_HW_INT=1 -> int_req_o=1. int_i[5] input absent, IP[7] follows timer only.
REQ-025 MEM writes Status=0xABCD with WB writing Status=0x1234 and raddr_i=12 -> rdata_o=status_o=0xABCD same cycle.

Source files
------------

// File: rtl/cp0_ctrl.sv
// CP0 control block: exception/interrupt state, Status/Cause/EPC with MEM/WB forwarding.
// Optional Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_ctrl #(
  parameter int unsigned N_HW_INT  = 6,
  parameter int unsigned COUNT_DIV = 1,
  parameter logic [31:0] PRID_VAL  = 32'h004C_0102
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_we_i,
  input  logic [4:0]          wb_waddr_i,
  input  logic [31:0]         wb_wdata_i,
  input  logic                mem_we_i,
  input  logic [4:0]          mem_waddr_i,
  input  logic [31:0]         mem_wdata_i,
  input  logic [4:0]          raddr_i,
  input  logic [N_HW_INT-1:0] int_i,
  input  logic                exc_valid_i,
  input  logic [4:0]          exc_code_i,
  input  logic [31:0]         exc_pc_i,
  input  logic                exc_bd_i,
  input  logic [31:0]         exc_badvaddr_i,
  input  logic                eret_i,
  output logic [31:0]         rdata_o,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o,
  output logic                timer_int_o,
  output logic                int_req_o
);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;
  localparam logic [4:0] A_CONFIG   = 5'd16;

  localparam logic [31:0] CONFIG_VAL  = 32'h0000_8000;
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

  if (N_HW_INT < 1 || N_HW_INT > 6) begin : g_bad_n_hw_int
    $error("cp0_ctrl: N_HW_INT out of range");
  end
  if (COUNT_DIV < 1 || COUNT_DIV > 16) begin : g_bad_count_div
    $error("cp0_ctrl: COUNT_DIV out of range");
  end

  logic [31:0] status_q, epc_q, badvaddr_q;
  logic        bd_q, iv_q, wp_q;
  logic [1:0]  ip_sw_q;
  logic [5:0]  ip_hw_q;
  logic [4:0]  exc_code_q;
  logic [31:0] count_v, compare_v;
  logic        timer_q;
  logic [31:0] cause_v, rd_base, rd_fwd;

  // Write mask per address: read-only and unmapped registers take no bits.
  function automatic logic [31:0] wmask(input logic [4:0] a);
    case (a)
      A_STATUS, A_EPC, A_BADVADDR: wmask = '1;
      A_CAUSE:                     wmask = CAUSE_WMASK;
`ifdef CP0_TIMER_EN
      A_COUNT, A_COMPARE:          wmask = '1;
`endif
      default:                     wmask = '0;
    endcase
  endfunction

  // Layer WB then MEM (younger) writes over the committed value of register a.
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] base,
                                      input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                                      input logic mwe, input logic [4:0] ma, input logic [31:0] md);
    logic [31:0] v;
    v = base;
    if (wwe && wa == a) v = (v & ~wmask(a)) | (wd & wmask(a));
    if (mwe && ma == a) v = (v & ~wmask(a)) | (md & wmask(a));
    return v;
  endfunction

  logic wb_status, wb_cause, wb_epc, wb_badvaddr;
  assign wb_status   = wb_we_i && wb_waddr_i == A_STATUS;
  assign wb_cause    = wb_we_i && wb_waddr_i == A_CAUSE;
  assign wb_epc      = wb_we_i && wb_waddr_i == A_EPC;
  assign wb_badvaddr = wb_we_i && wb_waddr_i == A_BADVADDR;

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= 32'h1000_0000;
      epc_q      <= '0;
      badvaddr_q <= '0;
      bd_q       <= 1'b0;
      iv_q       <= 1'b0;
      wp_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      exc_code_q <= '0;
    end else begin
      ip_hw_q <= 6'(int_i);
      if (wb_status) status_q <= wb_wdata_i;
      // EXL is overridden after the WB write so exception/eret take the field.
      if (exc_valid_i)  status_q[1] <= 1'b1;
      else if (eret_i)  status_q[1] <= 1'b0;
      if (wb_cause) begin
        ip_sw_q <= wb_wdata_i[9:8];
        wp_q    <= wb_wdata_i[22];
        iv_q    <= wb_wdata_i[23];
      end
      if (exc_valid_i) begin
        exc_code_q <= exc_code_i;
        if (!status_q[1]) begin
          bd_q  <= exc_bd_i;
          epc_q <= exc_pc_i - (exc_bd_i ? 32'd4 : 32'd0);
        end
      end else if (wb_epc) begin
        epc_q <= wb_wdata_i;
      end
      if (exc_valid_i && (exc_code_i == 5'd4 || exc_code_i == 5'd5))
        badvaddr_q <= exc_badvaddr_i;
      else if (wb_badvaddr)
        badvaddr_q <= wb_wdata_i;
    end
  end

`ifdef CP0_TIMER_EN
  localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);
  logic [3:0]  div_q;
  logic [31:0] count_q, compare_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      timer_q   <= 1'b0;
    end else begin
      if (wb_we_i && wb_waddr_i == A_COUNT) begin
        count_q <= wb_wdata_i;
        div_q   <= '0;
      end else if (div_q == DIV_LAST) begin
        count_q <= count_q + 32'd1;
        div_q   <= '0;
      end else begin
        div_q <= div_q + 4'd1;
      end
      if (wb_we_i && wb_waddr_i == A_COMPARE) begin
        compare_q <= wb_wdata_i;
        timer_q   <= 1'b0;
      end else if (count_q == compare_q) begin
        timer_q <= 1'b1;
      end
    end
  end

  assign count_v   = count_q;
  assign compare_v = compare_q;
`else
  assign count_v   = '0;
  assign compare_v = '0;
  assign timer_q   = 1'b0;
`endif

  assign cause_v = {bd_q, 7'b0, iv_q, wp_q, 6'b0, ip_hw_q[5] | timer_q, ip_hw_q[4:0],
                    ip_sw_q, 1'b0, exc_code_q, 2'b0};

  always_comb begin
    rd_base = '0;
    case (raddr_i)
      A_BADVADDR: rd_base = badvaddr_q;
      A_COUNT:    rd_base = count_v;
      A_COMPARE:  rd_base = compare_v;
      A_STATUS:   rd_base = status_q;
      A_CAUSE:    rd_base = cause_v;
      A_EPC:      rd_base = epc_q;
      A_PRID:     rd_base = PRID_VAL;
      A_CONFIG:   rd_base = CONFIG_VAL;
      default:    rd_base = '0;
    endcase
  end

  always_comb begin
    rd_fwd   = fwd(raddr_i,  rd_base,  wb_we_i, wb_waddr_i, wb_wdata_i, mem_we_i, mem_waddr_i, mem_wdata_i);
    status_o = fwd(A_STATUS, status_q, wb_we_i, wb_waddr_i, wb_wdata_i, mem_we_i, mem_waddr_i, mem_wdata_i);
    cause_o  = fwd(A_CAUSE,  cause_v,  wb_we_i, wb_waddr_i, wb_wdata_i, mem_we_i, mem_waddr_i, mem_wdata_i);
    epc_o    = fwd(A_EPC,    epc_q,    wb_we_i, wb_waddr_i, wb_wdata_i, mem_we_i, mem_waddr_i, mem_wdata_i);
  end

  assign rdata_o     = rst ? '0 : rd_fwd;
  assign timer_int_o = timer_q & ~rst;
  assign int_req_o   = ~rst & status_o[0] & ~status_o[1] & (|(cause_o[15:8] & status_o[15:8]));

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl (N_HW_INT=1, COUNT_DIV=2) with a queue scoreboard.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we_i, mem_we_i, exc_valid_i, exc_bd_i, eret_i;
  logic [4:0]  wb_waddr_i, mem_waddr_i, raddr_i, exc_code_i;
  logic [31:0] wb_wdata_i, mem_wdata_i, exc_pc_i, exc_badvaddr_i;
  logic [0:0]  int_i;
  logic [31:0] rdata_o, status_o, cause_o, epc_o;
  logic        timer_int_o, int_req_o;

  always #5 clk = ~clk;

  cp0_ctrl #(.N_HW_INT(1), .COUNT_DIV(2)) dut (
    .clk(clk), .rst(rst),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .raddr_i(raddr_i), .int_i(int_i),
    .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
    .exc_bd_i(exc_bd_i), .exc_badvaddr_i(exc_badvaddr_i), .eret_i(eret_i),
    .rdata_o(rdata_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .timer_int_o(timer_int_o), .int_req_o(int_req_o)
  );

`ifdef CP0_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  localparam int unsigned S_RDATA = 0, S_STATUS = 1, S_CAUSE = 2, S_EPC = 3, S_TIMER = 4, S_INTREQ = 5;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic logic [31:0] observe(input int unsigned sel);
    case (sel)
      S_RDATA:  return rdata_o;
      S_STATUS: return status_o;
      S_CAUSE:  return cause_o;
      S_EPC:    return epc_o;
      S_TIMER:  return {31'b0, timer_int_o};
      default:  return {31'b0, int_req_o};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int unsigned sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_checks++;
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    wb_we_i = 1'b0; mem_we_i = 1'b0; exc_valid_i = 1'b0; eret_i = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we_i = 1'b1; wb_waddr_i = a; wb_wdata_i = d;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd, input logic [31:0] bva);
    exc_valid_i = 1'b1; exc_code_i = code; exc_pc_i = pc; exc_bd_i = bd; exc_badvaddr_i = bva;
  endtask

  initial begin
    rst = 1'b1; idle();
    wb_waddr_i = '0; wb_wdata_i = '0; mem_waddr_i = '0; mem_wdata_i = '0;
    raddr_i = 5'd12; int_i = '0;
    exc_code_i = '0; exc_pc_i = '0; exc_bd_i = 1'b0; exc_badvaddr_i = '0;

    // Reset state
    cyc(2);
    expect_val("rst_rdata", S_RDATA, 32'h0);
    expect_val("rst_intreq", S_INTREQ, 32'h0);
    expect_val("rst_timer", S_TIMER, 32'h0);
    check_all();
    rst = 1'b0;
    expect_val("rel_status", S_STATUS, 32'h1000_0000);
    expect_val("rel_rd_status", S_RDATA, 32'h1000_0000);
    expect_val("rel_cause", S_CAUSE, 32'h0);
    expect_val("rel_epc", S_EPC, 32'h0);
    expect_val("rel_timer", S_TIMER, 32'h0);
    check_all();

    // Count/Compare both 0 at release: match sets timer one edge later
    cyc(1);
    expect_val("timer_zero_match", S_TIMER, {31'b0, TEN});
    check_all();
    cyc(9);
    raddr_i = 5'd9;
    expect_val("count_after_10", S_RDATA, TEN ? 32'd5 : 32'd0);
    check_all();

    // Count write: forwarded, then committed, divider restarts
    wb_write(5'd9, 32'd7);
    expect_val("count_fwd", S_RDATA, TEN ? 32'd7 : 32'd0);
    check_all();
    cyc(1); idle();
    expect_val("count_wr", S_RDATA, TEN ? 32'd7 : 32'd0);
    check_all();
    cyc(1);
    expect_val("count_div_reset", S_RDATA, TEN ? 32'd7 : 32'd0);
    check_all();
    cyc(1);
    expect_val("count_inc", S_RDATA, TEN ? 32'd8 : 32'd0);
    expect_val("timer_sticky", S_TIMER, {31'b0, TEN});
    check_all();

    // Compare=3, Count=1, then free-run to the match
    wb_write(5'd11, 32'd3);
    cyc(1);
    expect_val("timer_clr_cmp", S_TIMER, 32'h0);
    check_all();
    wb_write(5'd9, 32'd1);
    cyc(1); idle();
    cyc(4);
    expect_val("timer_before", S_TIMER, 32'h0);
    check_all();
    cyc(1);
    expect_val("timer_set", S_TIMER, {31'b0, TEN});
    check_all();
    cyc(6);
    expect_val("timer_hold", S_TIMER, {31'b0, TEN});
    check_all();
    wb_write(5'd11, 32'd0);
    cyc(1); idle();
    expect_val("timer_clr0", S_TIMER, 32'h0);
    check_all();
    cyc(1);
    expect_val("timer_stay0", S_TIMER, 32'h0);
    check_all();

    // Exceptions
    exc(5'd8, 32'h100, 1'b1, 32'hDEAD);
    cyc(1); idle();
    raddr_i = 5'd14;
    expect_val("exc1_epc", S_EPC, 32'hFC);
    expect_val("exc1_rd_epc", S_RDATA, 32'hFC);
    expect_val("exc1_cause", S_CAUSE, 32'h8000_0020);
    expect_val("exc1_status", S_STATUS, 32'h1000_0002);
    check_all();
    raddr_i = 5'd8;
    expect_val("exc1_bva_kept", S_RDATA, 32'h0);
    check_all();
    exc(5'd8, 32'h200, 1'b0, 32'h0);
    cyc(1); idle();
    expect_val("exc2_epc", S_EPC, 32'hFC);
    expect_val("exc2_cause", S_CAUSE, 32'h8000_0020);
    check_all();
    exc(5'd4, 32'h300, 1'b0, 32'h1003);
    eret_i = 1'b1;
    cyc(1); idle();
    expect_val("exc3_bva", S_RDATA, 32'h1003);
    expect_val("exc3_exl", S_STATUS, 32'h1000_0002);
    expect_val("exc3_cause", S_CAUSE, 32'h8000_0010);
    expect_val("exc3_epc", S_EPC, 32'hFC);
    check_all();
    eret_i = 1'b1;
    cyc(1); idle();
    expect_val("eret_status", S_STATUS, 32'h1000_0000);
    check_all();

    // Interrupt request
    wb_write(5'd12, 32'h0000_0401);
    int_i = 1'b1;
    expect_val("int_ip_not_yet", S_INTREQ, 32'h0);
    check_all();
    cyc(1); idle();
    expect_val("int_req", S_INTREQ, 32'h1);
    expect_val("int_cause", S_CAUSE, 32'h8000_0410);
    check_all();
    exc(5'd0, 32'h400, 1'b0, 32'h0);
    cyc(1); idle();
    expect_val("int_exl_mask", S_INTREQ, 32'h0);
    expect_val("exc4_epc", S_EPC, 32'h400);
    expect_val("exc4_cause", S_CAUSE, 32'h0000_0400);
    check_all();
    eret_i = 1'b1;
    cyc(1); idle();
    expect_val("int_after_eret", S_INTREQ, 32'h1);
    check_all();
    int_i = 1'b0;
    cyc(1);
    expect_val("int_drop", S_INTREQ, 32'h0);
    expect_val("cause_clear", S_CAUSE, 32'h0);
    check_all();

    // Forwarding priority
    wb_write(5'd12, 32'h1234);
    mem_we_i = 1'b1; mem_waddr_i = 5'd12; mem_wdata_i = 32'hABCD;
    raddr_i = 5'd12;
    expect_val("fwd_mem_rd", S_RDATA, 32'hABCD);
    expect_val("fwd_mem_status", S_STATUS, 32'hABCD);
    check_all();
    mem_we_i = 1'b0;
    raddr_i = 5'd14;
    expect_val("fwd_wb_status", S_STATUS, 32'h1234);
    expect_val("fwd_indep_rd", S_RDATA, 32'h400);
    check_all();
    cyc(1); idle();
    expect_val("wb_status_commit", S_STATUS, 32'h1234);
    check_all();
    mem_we_i = 1'b1; mem_waddr_i = 5'd13; mem_wdata_i = 32'hFFFF_FFFF;
    raddr_i = 5'd13;
    expect_val("fwd_cause_mask", S_CAUSE, 32'h00C0_0300);
    expect_val("fwd_cause_rd", S_RDATA, 32'h00C0_0300);
    check_all();
    mem_we_i = 1'b0;
    expect_val("mem_no_commit", S_CAUSE, 32'h0);
    check_all();
    wb_write(5'd13, 32'hFFFF_FFFF);
    cyc(1); idle();
    expect_val("cause_wr_mask", S_RDATA, 32'h00C0_0300);
    check_all();

    // Read-only and unmapped
    wb_write(5'd15, 32'h0);
    raddr_i = 5'd15;
    expect_val("prid_ro", S_RDATA, 32'h004C_0102);
    check_all();
    idle();
    raddr_i = 5'd16;
    expect_val("config", S_RDATA, 32'h0000_8000);
    check_all();
    wb_write(5'd5, 32'hFFFF);
    raddr_i = 5'd5;
    expect_val("unmapped", S_RDATA, 32'h0);
    check_all();
    cyc(1); idle();

    // Reset during an exception
    rst = 1'b1;
    exc(5'd8, 32'h500, 1'b0, 32'h0);
    raddr_i = 5'd14;
    expect_val("rst_mid_rdata", S_RDATA, 32'h0);
    expect_val("rst_mid_intreq", S_INTREQ, 32'h0);
    check_all();
    cyc(1);
    rst = 1'b0; idle();
    expect_val("rst_exc_epc", S_EPC, 32'h0);
    expect_val("rst_exc_status", S_STATUS, 32'h1000_0000);
    expect_val("rst_exc_cause", S_CAUSE, 32'h0);
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
